mul_result_checker: RTL

//  Scoreboard stage directly downstream of the small unsigned multiplier. Consumes {a, b, product}

---
 rtl/mul_result_checker.sv | 77 +++++++
 1 files changed

// File: rtl/mul_result_checker.sv
// mul_result_checker: two-stage scoreboard that recomputes a truncated a*b and grades each product beat
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_a/in_b/in_product upstream beat;
//   out_valid/out_ready/out_pass/out_expected/out_ovf graded result; clear zeroes the statistics;
//   pass_count/err_count saturating hand-off counters; sticky_fail latches any failing hand-off.
module mul_result_checker #(
  parameter int A_W   = 3,
  parameter int B_W   = 3,
  parameter int P_W   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [P_W-1:0]   in_product,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pass,
  output logic [P_W-1:0]   out_expected,
  output logic             out_ovf,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             sticky_fail
);
  logic             s1_valid;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [P_W-1:0]   s1_p;
  logic [A_W+B_W-1:0] full;
  logic             s2_load;
  logic             hand_off;
  assign full     = {{B_W{1'b0}}, s1_a} * {{A_W{1'b0}}, s1_b};
  assign hand_off = out_valid && out_ready;
  assign s2_load  = !out_valid || out_ready;
  // S1 is free when empty or when it drains into S2 this cycle
  assign in_ready = !s1_valid || s2_load;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_p         <= '0;
      out_valid    <= 1'b0;
      out_pass     <= 1'b0;
      out_expected <= '0;
      out_ovf      <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_p <= in_product;
      end
      if (s2_load) out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        out_expected <= full[P_W-1:0];
        out_pass     <= s1_p == full[P_W-1:0];
        // bits above P_W are lost by the multiplier's truncation
        out_ovf      <= (full >> P_W) != '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pass_count  <= '0;
      err_count   <= '0;
      sticky_fail <= 1'b0;
    end else if (hand_off) begin
      if (out_pass && pass_count != '1) pass_count <= pass_count + CNT_W'(1);
      if (!out_pass && err_count != '1) err_count <= err_count + CNT_W'(1);
      if (!out_pass) sticky_fail <= 1'b1;
    end
  end
endmodule
